mag_comp_seq: RTL and testbench

MAG_COMP_SEQ -- requirements
Module: mag_comp_seq

---
 rtl/mag_comp_pkg.sv | 21 ++
 rtl/mag_comp_digit.sv | 16 +
 rtl/mag_comp_seq.sv | 127 ++++++++++++
 tb/tb_mag_comp_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mag_comp_pkg.sv
// Shared types and sizing helpers for the sequential magnitude comparator.
package mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Index register is never narrower than one bit, even for a single digit.
  function automatic int calc_idx_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_comp_digit.sv
// Combinational compare of one DIGIT-wide slice of the two operands.
module mag_comp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/mag_comp_seq.sv
// Sequential magnitude comparator: scans DIGIT bits per cycle, MSB first,
// with optional early exit on the first differing digit.
module mag_comp_seq
  import mag_comp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int IDX_W = calc_idx_w(WIDTH, DIGIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("mag_comp_seq: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             dec_gt_q;
  logic             dec_lt_q;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic             dig_gt;
  logic             dig_lt;
  logic             dig_eq;
  logic             accept;
  logic             prior;
  logic             decided;
  logic             res_gt;
  logic             res_lt;
  logic             last;

  assign a_dig = a_q[idx*DIGIT +: DIGIT];
  assign b_dig = b_q[idx*DIGIT +: DIGIT];

  mag_comp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .gt (dig_gt),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  // Once a digit has decided the outcome, later digits only pass it along.
  assign accept  = start && (state != RUN);
  assign prior   = dec_gt_q || dec_lt_q;
  assign decided = prior || !dig_eq;
  assign res_gt  = prior ? dec_gt_q : dig_gt;
  assign res_lt  = prior ? dec_lt_q : dig_lt;
  assign last    = (idx == '0) || ((EARLY_EXIT != 0) && decided);

  // NOTE: non-blocking assignments throughout, so every register in this block
  // samples the pre-edge value of every other one regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dec_gt_q <= 1'b0;
      dec_lt_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gt       <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            // Flipping the sign bit maps two's complement onto offset binary.
            a_q      <= a ^ (signed_mode ? SIGN_BIT : '0);
            b_q      <= b ^ (signed_mode ? SIGN_BIT : '0);
            idx      <= LAST_IDX;
            dec_gt_q <= 1'b0;
            dec_lt_q <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            eq       <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dec_gt_q <= res_gt;
          dec_lt_q <= res_lt;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            gt    <= res_gt;
            lt    <= res_lt;
            eq    <= !decided;
            state <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comp_seq.sv
// Bench for mag_comp_seq: early-exit and full-scan instances share stimulus and
// are checked every cycle against a latency/result model, plus directed cases.
module tb_mag_comp_seq;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;

  // Index 0: EARLY_EXIT=1 instance, index 1: EARLY_EXIT=0 instance.
  logic [1:0] busy, done, gt, lt, eq;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mag_comp_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut_early (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy[0]), .done(done[0]), .gt(gt[0]), .lt(lt[0]), .eq(eq[0])
  );

  mag_comp_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .signed_mode(signed_mode),
    .busy(busy[1]), .done(done[1]), .gt(gt[1]), .lt(lt[1]), .eq(eq[1])
  );

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected {gt,lt,eq} from plain arithmetic comparison.
  function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic sm);
    logic g, l;
    if (sm) begin
      g = $signed(x) > $signed(y);
      l = $signed(x) < $signed(y);
    end else begin
      g = x > y;
      l = x < y;
    end
    return {g, l, !(g || l)};
  endfunction

  // Number of busy cycles: position of the first differing digit, or all digits.
  function automatic int scan_len(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input bit early);
    if (!early) return NDIG;
    for (int i = 1; i <= NDIG; i++)
      if ((x >> (WIDTH - i*DIGIT)) != (y >> (WIDTH - i*DIGIT))) return i;
    return NDIG;
  endfunction

  int         m_left [2] = '{0, 0};
  logic       m_done [2] = '{1'b0, 1'b0};
  logic [2:0] m_res  [2] = '{3'b0, 3'b0};
  logic [2:0] m_pend [2] = '{3'b0, 3'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_left[d] <= 0;
        m_done[d] <= 1'b0;
        m_res[d]  <= 3'b000;
      end else if (m_left[d] == 0 && start) begin
        m_left[d] <= scan_len(a, b, d == 0);
        m_done[d] <= 1'b0;
        m_res[d]  <= 3'b000;
        m_pend[d] <= ref_res(a, b, signed_mode);
      end else if (m_left[d] > 0) begin
        m_left[d] <= m_left[d] - 1;
        if (m_left[d] == 1) begin
          m_done[d] <= 1'b1;
          m_res[d]  <= m_pend[d];
        end
      end else begin
        m_done[d] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("busy[%0d]", d), int'(busy[d]), int'(m_left[d] > 0));
        check($sformatf("done[%0d]", d), int'(done[d]), int'(m_done[d]));
        check($sformatf("gt_lt_eq[%0d]", d), int'({gt[d], lt[d], eq[d]}), int'(m_res[d]));
      end
    end
  end

  task automatic wait_idle();
    for (int j = 0; j < 40; j++) begin
      if (busy == 2'b00 && done == 2'b00) return;
      @(negedge clk);
    end
    check("idle_timeout", 1, 0);
  endtask

  // Presents a start for one cycle; returns at the negedge of cycle T+1.
  task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic sm);
    a = aa;
    b = bb;
    signed_mode = sm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after the accepting cycle until each instance pulses done.
  task automatic measure(input bit pulse_mid, input logic [WIDTH-1:0] aa, input logic sm,
                         output int got0, output int got1,
                         output logic [2:0] r0, output logic [2:0] r1);
    got0 = -1; got1 = -1; r0 = 3'b0; r1 = 3'b0;
    for (int j = 1; j <= 4*NDIG + 4; j++) begin
      if (busy[0]) check("quiet_while_busy", int'({gt[0], lt[0], eq[0]}), 0);
      if (got0 < 0 && done[0]) begin got0 = j; r0 = {gt[0], lt[0], eq[0]}; end
      if (got1 < 0 && done[1]) begin got1 = j; r1 = {gt[1], lt[1], eq[1]}; end
      if (got0 >= 0 && got1 >= 0) break;
      if (pulse_mid && j == 2) begin
        start = 1'b1;
        a = ~aa;
        b = aa;
        signed_mode = ~sm;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic directed(input string name, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                          input logic sm, input logic [2:0] exp_res,
                          input int lat_e, input int lat_f, input bit pulse_mid);
    int g0, g1;
    logic [2:0] r0, r1;
    wait_idle();
    issue(aa, bb, sm);
    measure(pulse_mid, aa, sm, g0, g1, r0, r1);
    check({name, "_lat_early"}, g0, lat_e);
    check({name, "_lat_full"}, g1, lat_f);
    check({name, "_res_early"}, int'(r0), int'(exp_res));
    check({name, "_res_full"}, int'(r1), int'(exp_res));
  endtask

  initial begin
    int g0, g1;
    logic [2:0] r0, r1;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_busy", int'(busy[d]), 0);
      check("reset_done", int'(done[d]), 0);
      check("reset_flags", int'({gt[d], lt[d], eq[d]}), 0);
    end
    rst = 1'b0;
    check_en = 1'b1;

    directed("eq_1234",      16'h1234, 16'h1234, 1'b0, 3'b001, 5, 5, 1'b0);
    directed("u_8000_7fff",  16'h8000, 16'h7FFF, 1'b0, 3'b100, 2, 5, 1'b0);
    directed("s_8000_0001",  16'h8000, 16'h0001, 1'b1, 3'b010, 2, 5, 1'b0);
    directed("u_8000_0001",  16'h8000, 16'h0001, 1'b0, 3'b100, 2, 5, 1'b0);
    directed("u_12a4_12b4",  16'h12A4, 16'h12B4, 1'b0, 3'b010, 4, 5, 1'b1);
    directed("s_ffff_0000",  16'hFFFF, 16'h0000, 1'b1, 3'b010, 2, 5, 1'b0);
    directed("s_7fff_8000",  16'h7FFF, 16'h8000, 1'b1, 3'b100, 2, 5, 1'b0);

    // Back-to-back: a second start held during the DONE cycle.
    wait_idle();
    issue(16'h0001, 16'h0002, 1'b0);
    measure(1'b0, 16'h0001, 1'b0, g0, g1, r0, r1);
    check("b2b_first_res", int'(r0), 3'b010);
    issue(16'h0005, 16'h0003, 1'b0);
    check("b2b_busy_early", int'(busy[0]), 1);
    check("b2b_busy_full", int'(busy[1]), 1);
    measure(1'b0, 16'h0005, 1'b0, g0, g1, r0, r1);
    check("b2b_lat_early", g0, 5);
    check("b2b_res_early", int'(r0), 3'b100);
    check("b2b_res_full", int'(r1), 3'b100);

    // Reset during cycle T+2 of a full scan aborts with all outputs low.
    wait_idle();
    issue(16'h0F0F, 16'h0F0F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("midrst_busy", int'(busy[d]), 0);
      check("midrst_done", int'(done[d]), 0);
      check("midrst_flags", int'({gt[d], lt[d], eq[d]}), 0);
    end
    directed("eq_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 3'b001, 5, 5, 1'b0);

    // Random traffic with operand pairs biased toward shared leading digits.
    wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) == 0);
      signed_mode = $urandom_range(0, 1);
      a = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: b = WIDTH'($urandom);
        1: b = a;
        2: b = a ^ (WIDTH'(1) << $urandom_range(0, WIDTH-1));
        default: b = a ^ 16'h8000;
      endcase
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (2*NDIG + 4) @(negedge clk);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
